ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single-port 256x8 system RAM between two requesters:
  - port A: CPU control/datapath;
  - port B: debug/DMA loader.
- Round-robin arbitration with an optional bounded lock, so a requester can do atomic read-modify-write sequences.
- Sits between the requesters and the RAM macro. The RAM registers its address and write inputs on the clock edge; read data appears on q one cycle later.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.
- MAX_LOCK, 7, maximum cycles a locked owner may hold the RAM while the other port is waiting. Legal range 1..15.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_req_a / i_req_b  in  1  access request.
- i_we_a / i_we_b  in  1  1 = write, 0 = read.
- i_lock_a / i_lock_b  in  1  request to keep ownership after this access.
- i_addr_a / i_addr_b  in  ADDR_W  access address.
- i_wdata_a / i_wdata_b  in  DATA_W  write data.
- o_gnt_a / o_gnt_b  out  1  access accepted on this clock edge (combinational).
- o_rvalid_a / o_rvalid_b  out  1  read data valid for that port (registered).
- o_rdata  out  DATA_W  read data, shared by both ports, equals i_ram_q.
- o_ram_addr  out  ADDR_W  to RAM address.
- o_ram_data  out  DATA_W  to RAM write data.
- o_ram_wren  out  1  to RAM write enable.
- i_ram_q  in  DATA_W  RAM read data.
- o_owner  out  2  lock owner status: 00 none, 01 A, 10 B.

Behaviour:
- Reset (async, i_reset_n=0):
  - state IDLE; m_last = B, so A wins the first tie; lock count 0.
  - o_rvalid_a/b = 0, o_owner = 00.
  - With no requests, all grants and o_ram_wren are 0.
  - Any pending rvalid is dropped. Reset mid-lock releases the lock.
- Grant is combinational in the same cycle as the request:
  - A requester holds req/we/addr/wdata stable until it sees gnt high.
  - The access executes on that rising edge.
  - At most one grant per cycle.
- RAM drive:
  - o_ram_addr/o_ram_data mux the granted port's address/data.
  - When nothing is granted they mux port A, with o_ram_wren = 0.
  - o_ram_wren = (gnt_a & i_we_a) | (gnt_b & i_we_b).
- Read return:
  - o_rvalid_x is a registered copy of (gnt_x & ~i_we_x). It is high exactly one cycle after the granted read.
  - o_rdata = i_ram_q.
  - Read latency is 1 cycle after the grant edge. Back-to-back reads give back-to-back rvalids.
- State IDLE:
  - Only one port requesting: that port is granted.
  - Both requesting: the port != m_last is granted.
  - m_last updates to the granted port on every grant.
  - If the granted port also has i_lock_x = 1: go to OWN_x, lock count <= 1.
- State OWN_x:
  - Only x can be granted; the other port's requests stall with gnt = 0.
  - Lock count increments each cycle and saturates at MAX_LOCK.
  - If x has i_req_x & ~i_lock_x: x is granted, then go to IDLE (last access of the sequence).
  - If x has ~i_req_x & ~i_lock_x: go to IDLE, no grant.
  - If x holds i_lock_x with no request: stay in OWN_x (idle hold).
- Forced release:
  - Trigger: in OWN_x, lock count == MAX_LOCK and the other port is requesting.
  - That cycle: no grant to x. Next state IDLE, m_last <= x, so the other port wins next cycle.
  - If the other port is not requesting, x keeps ownership beyond MAX_LOCK.
- o_owner:
  - 01 in OWN_A, 10 in OWN_B, else 00.
  - Registered; reflects the current state.
- Simultaneous events:
  - A write and a read of the same address by different ports in consecutive cycles follow grant order. The read returns the written value if the write was granted first.
  - A lock request arriving while in OWN_x from the other port is ignored until that port is granted from IDLE.
- Addresses wrap naturally; no range checks.

Test Plan:
- Reset: hold i_reset_n=0 mid-transaction with i_req_a=1 -> all o_rvalid=0, o_owner=00, o_ram_wren=0 asynchronously. After release, A's first request is granted in the same cycle.
- Single read: A writes 0x5A to addr 0x10, then reads 0x10 -> gnt_a on each request cycle; o_rvalid_a=1 one cycle after the read grant with o_rdata=0x5A; o_rvalid_b stays 0.
- Tie round-robin: A and B both hold req for 4 cycles (reads of 0x01 and 0x02) -> grants alternate A, B, A, B, with matching alternating rvalids one cycle later.
- Lock: A does a locked read of 0x20, then an unlocked write of 0x21 to 0x20, while B requests continuously -> o_owner=01, B gets no grant until A's write completes. Then B is granted; readback of 0x20 = 0x21.
- Forced release: MAX_LOCK=3, A holds i_lock_a=1 with continuous requests while B requests -> A is granted for exactly 3 cycles, then o_gnt_b=1 on the next cycle and o_owner returns to 00.
- Write priority: B writes 0xFF to 0x80 in the same cycle that A requests a read of 0x80, with m_last=A -> B is granted first, A the next cycle, and A's rvalid returns 0xFF.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one single-port synchronous RAM between two requesters.
//   Port A : CPU control/datapath
//   Port B : debug/DMA loader
// Arbitration is round-robin. A granted requester may also take a bounded
// lock, which keeps ownership across several accesses so that it can do
// atomic read-modify-write sequences.
//
// Ports
//   i_clk, i_reset_n           clock (rising edge), async active-low reset
//   i_req_x, i_we_x, i_lock_x  request, write (1) / read (0), keep ownership
//   i_addr_x, i_wdata_x        access address and write data
//   o_gnt_x                    access accepted on this clock edge (combinational)
//   o_rvalid_x                 read data valid for port x (registered)
//   o_rdata                    shared read data (straight from i_ram_q)
//   o_ram_addr/data/wren       drive to the RAM macro
//   i_ram_q                    RAM read data, one cycle after the address edge
//   o_owner                    lock owner: 00 none, 01 A, 10 B
module ram_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 7
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_req_a,
  input  logic              i_req_b,
  input  logic              i_we_a,
  input  logic              i_we_b,
  input  logic              i_lock_a,
  input  logic              i_lock_b,
  input  logic [ADDR_W-1:0] i_addr_a,
  input  logic [ADDR_W-1:0] i_addr_b,
  input  logic [DATA_W-1:0] i_wdata_a,
  input  logic [DATA_W-1:0] i_wdata_b,
  output logic              o_gnt_a,
  output logic              o_gnt_b,
  output logic              o_rvalid_a,
  output logic              o_rvalid_b,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_data,
  output logic              o_ram_wren,
  input  logic [DATA_W-1:0] i_ram_q,
  output logic [1:0]        o_owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  localparam logic [3:0] LP_MAX_LOCK = 4'(MAX_LOCK);

  state_t     r_state;
  state_t     w_next_state;
  logic       r_last_b;
  logic       w_next_last_b;
  logic [3:0] r_lock_cnt;
  logic [3:0] w_next_lock_cnt;
  logic [3:0] w_cnt_inc;
  logic       w_gnt_a_raw;
  logic       w_gnt_b_raw;
  logic       w_gnt_a;
  logic       w_gnt_b;
  logic       r_rvalid_a;
  logic       r_rvalid_b;

  assign w_cnt_inc = (r_lock_cnt == LP_MAX_LOCK) ? LP_MAX_LOCK : r_lock_cnt + 4'd1;

  // Grant and next-state logic. r_last_b remembers who was served last so
  // that a tie goes to the other port. While a port owns the RAM the other
  // one is stalled, unless the owner has used up its lock budget and the
  // other port is actually waiting; then the owner is skipped for one cycle
  // and marked as last so the waiting port wins from IDLE.
  always_comb begin
    w_gnt_a_raw     = 1'b0;
    w_gnt_b_raw     = 1'b0;
    w_next_state    = r_state;
    w_next_last_b   = r_last_b;
    w_next_lock_cnt = r_lock_cnt;
    case (r_state)
      IDLE: begin
        w_next_lock_cnt = 4'd0;
        if (i_req_a && (!i_req_b || r_last_b)) begin
          w_gnt_a_raw   = 1'b1;
          w_next_last_b = 1'b0;
          if (i_lock_a) begin
            w_next_state    = OWN_A;
            w_next_lock_cnt = 4'd1;
          end
        end else if (i_req_b) begin
          w_gnt_b_raw   = 1'b1;
          w_next_last_b = 1'b1;
          if (i_lock_b) begin
            w_next_state    = OWN_B;
            w_next_lock_cnt = 4'd1;
          end
        end
      end
      OWN_A: begin
        w_next_lock_cnt = w_cnt_inc;
        if ((r_lock_cnt == LP_MAX_LOCK) && i_req_b) begin
          w_next_state    = IDLE;
          w_next_last_b   = 1'b0;
          w_next_lock_cnt = 4'd0;
        end else begin
          w_gnt_a_raw = i_req_a;
          if (!i_lock_a) begin
            w_next_state    = IDLE;
            w_next_lock_cnt = 4'd0;
          end
        end
      end
      OWN_B: begin
        w_next_lock_cnt = w_cnt_inc;
        if ((r_lock_cnt == LP_MAX_LOCK) && i_req_a) begin
          w_next_state    = IDLE;
          w_next_last_b   = 1'b1;
          w_next_lock_cnt = 4'd0;
        end else begin
          w_gnt_b_raw = i_req_b;
          if (!i_lock_b) begin
            w_next_state    = IDLE;
            w_next_lock_cnt = 4'd0;
          end
        end
      end
      default: begin
        w_next_state    = IDLE;
        w_next_lock_cnt = 4'd0;
      end
    endcase
  end

  // Grants are masked while reset is asserted so nothing reaches the RAM
  // even if a requester keeps its request up through reset.
  assign w_gnt_a = w_gnt_a_raw & i_reset_n;
  assign w_gnt_b = w_gnt_b_raw & i_reset_n;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= IDLE;
      r_last_b   <= 1'b1;
      r_lock_cnt <= 4'd0;
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_last_b   <= w_next_last_b;
      r_lock_cnt <= w_next_lock_cnt;
      r_rvalid_a <= w_gnt_a & ~i_we_a;
      r_rvalid_b <= w_gnt_b & ~i_we_b;
    end
  end

  assign o_gnt_a    = w_gnt_a;
  assign o_gnt_b    = w_gnt_b;
  assign o_rvalid_a = r_rvalid_a;
  assign o_rvalid_b = r_rvalid_b;
  assign o_rdata    = i_ram_q;

  // Port A is the default RAM source when nothing is granted; wren keeps
  // that idle drive harmless.
  assign o_ram_addr = w_gnt_b ? i_addr_b  : i_addr_a;
  assign o_ram_data = w_gnt_b ? i_wdata_b : i_wdata_a;
  assign o_ram_wren = (w_gnt_a & i_we_a) | (w_gnt_b & i_we_b);

  assign o_owner = (r_state == OWN_A) ? 2'b01 :
                   (r_state == OWN_B) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed bench for ram_arbiter (built with MAX_LOCK = 3) driving a
// behavioural 256x8 synchronous RAM. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rstN;
  logic       reqA, reqB, weA, weB, lockA, lockB;
  logic [7:0] addrA, addrB, wdataA, wdataB;
  logic       gntA, gntB, rvalidA, rvalidB, ramWren;
  logic [7:0] rdata, ramAddr, ramData, ramQ;
  logic [1:0] owner;
  int         total = 0;
  int         bad = 0;

  logic [7:0] mem [256];
  bit         ramReady;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_LOCK(3)) dut (
    .i_clk(clk), .i_reset_n(rstN),
    .i_req_a(reqA), .i_req_b(reqB),
    .i_we_a(weA), .i_we_b(weB),
    .i_lock_a(lockA), .i_lock_b(lockB),
    .i_addr_a(addrA), .i_addr_b(addrB),
    .i_wdata_a(wdataA), .i_wdata_b(wdataB),
    .o_gnt_a(gntA), .o_gnt_b(gntB),
    .o_rvalid_a(rvalidA), .o_rvalid_b(rvalidB),
    .o_rdata(rdata),
    .o_ram_addr(ramAddr), .o_ram_data(ramData), .o_ram_wren(ramWren),
    .i_ram_q(ramQ),
    .o_owner(owner)
  );

  // Read-first synchronous RAM; unwritten location k holds k + 0x40.
  always @(posedge clk) begin
    if (!ramReady) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i + 64);
      ramReady <= 1'b1;
    end else begin
      if (ramWren) mem[ramAddr] <= ramData;
      ramQ <= mem[ramAddr];
    end
  end

  task automatic applyStimulus(input logic rA, input logic wA, input logic lA,
                               input logic [7:0] adA, input logic [7:0] dA,
                               input logic rB, input logic wB, input logic lB,
                               input logic [7:0] adB, input logic [7:0] dB);
    reqA = rA; weA = wA; lockA = lA; addrA = adA; wdataA = dA;
    reqB = rB; weB = wB; lockB = lB; addrB = adB; wdataB = dB;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for the falling edge and checks the per-cycle handshake outputs;
  // rdata is only compared when a read is being returned.
  task automatic checkCycle(input string tag, input logic ga, input logic gb,
                            input logic wr, input logic rva, input logic rvb,
                            input logic [1:0] own, input logic [7:0] rd);
    @(negedge clk);
    checkOutput({tag, ".gntA"}, {7'd0, gntA}, {7'd0, ga});
    checkOutput({tag, ".gntB"}, {7'd0, gntB}, {7'd0, gb});
    checkOutput({tag, ".wren"}, {7'd0, ramWren}, {7'd0, wr});
    checkOutput({tag, ".rvalidA"}, {7'd0, rvalidA}, {7'd0, rva});
    checkOutput({tag, ".rvalidB"}, {7'd0, rvalidB}, {7'd0, rvb});
    checkOutput({tag, ".owner"}, {6'd0, owner}, {6'd0, own});
    if (rva || rvb) checkOutput({tag, ".rdata"}, rdata, rd);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstN = 1'b0;
    applyStimulus(1, 1, 0, 8'h10, 8'h11, 0, 0, 0, 8'h00, 8'h00);
    checkCycle("reset", 0, 0, 0, 0, 0, 2'b00, 8'h00);
    nextCycle();
    rstN = 1'b1;

    // single write then read by A
    applyStimulus(1, 1, 0, 8'h10, 8'h5A, 0, 0, 0, 8'h00, 8'h00);
    checkCycle("s1", 1, 0, 1, 0, 0, 2'b00, 8'h00);
    checkOutput("s1.ramAddr", ramAddr, 8'h10);
    checkOutput("s1.ramData", ramData, 8'h5A);
    nextCycle();
    applyStimulus(1, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    checkCycle("s2", 1, 0, 0, 0, 0, 2'b00, 8'h00);
    nextCycle();
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h02, 8'h00);
    checkCycle("s3", 0, 1, 0, 1, 0, 2'b00, 8'h5A);
    nextCycle();

    // tie round-robin
    applyStimulus(1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
    checkCycle("s4", 1, 0, 0, 0, 1, 2'b00, 8'h42);
    nextCycle();
    checkCycle("s5", 0, 1, 0, 1, 0, 2'b00, 8'h41);
    nextCycle();
    checkCycle("s6", 1, 0, 0, 0, 1, 2'b00, 8'h42);
    nextCycle();
    checkCycle("s7", 0, 1, 0, 1, 0, 2'b00, 8'h41);
    nextCycle();
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    checkCycle("s8", 0, 0, 0, 0, 1, 2'b00, 8'h42);
    nextCycle();

    // locked read-modify-write by A while B waits
    applyStimulus(1, 0, 1, 8'h20, 8'h00, 1, 0, 0, 8'h30, 8'h00);
    checkCycle("s9", 1, 0, 0, 0, 0, 2'b00, 8'h00);
    nextCycle();
    applyStimulus(1, 1, 0, 8'h20, 8'h21, 1, 0, 0, 8'h30, 8'h00);
    checkCycle("s10", 1, 0, 1, 1, 0, 2'b01, 8'h60);
    nextCycle();
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h30, 8'h00);
    checkCycle("s11", 0, 1, 0, 0, 0, 2'b00, 8'h00);
    nextCycle();
    applyStimulus(1, 0, 0, 8'h20, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    checkCycle("s12", 1, 0, 0, 0, 1, 2'b00, 8'h70);
    nextCycle();
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    checkCycle("s13", 0, 0, 0, 1, 0, 2'b00, 8'h21);
    nextCycle();

    // forced release after MAX_LOCK cycles
    applyStimulus(1, 0, 1, 8'h03, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    checkCycle("s14", 1, 0, 0, 0, 0, 2'b00, 8'h00);
    nextCycle();
    applyStimulus(1, 0, 1, 8'h03, 8'h00, 1, 0, 0, 8'h04, 8'h00);
    checkCycle("s15", 1, 0, 0, 1, 0, 2'b01, 8'h43);
    nextCycle();
    checkCycle("s16", 1, 0, 0, 1, 0, 2'b01, 8'h43);
    nextCycle();
    checkCycle("s17", 0, 0, 0, 1, 0, 2'b01, 8'h43);
    nextCycle();
    checkCycle("s18", 0, 1, 0, 0, 0, 2'b00, 8'h00);
    nextCycle();

    // lock held past MAX_LOCK while B is quiet, then forced release
    applyStimulus(1, 0, 1, 8'h03, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    checkCycle("s19", 1, 0, 0, 0, 1, 2'b00, 8'h44);
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      checkCycle("s20", 1, 0, 0, 1, 0, 2'b01, 8'h43);
      nextCycle();
    end
    applyStimulus(1, 0, 1, 8'h03, 8'h00, 1, 0, 0, 8'h04, 8'h00);
    checkCycle("s23", 0, 0, 0, 1, 0, 2'b01, 8'h43);
    nextCycle();
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h04, 8'h00);
    checkCycle("s24", 0, 1, 0, 0, 0, 2'b00, 8'h00);
    nextCycle();

    // idle hold, then reset in the middle of a locked write
    applyStimulus(1, 0, 1, 8'h05, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    checkCycle("s25", 1, 0, 0, 0, 1, 2'b00, 8'h44);
    nextCycle();
    applyStimulus(0, 0, 1, 8'h05, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    checkCycle("s26", 0, 0, 0, 1, 0, 2'b01, 8'h45);
    nextCycle();
    checkCycle("s27", 0, 0, 0, 0, 0, 2'b01, 8'h00);
    nextCycle();
    applyStimulus(1, 0, 1, 8'h06, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    checkCycle("s28", 1, 0, 0, 0, 0, 2'b01, 8'h00);
    nextCycle();
    applyStimulus(1, 1, 1, 8'h07, 8'h99, 0, 0, 0, 8'h00, 8'h00);
    checkCycle("s29", 1, 0, 1, 1, 0, 2'b01, 8'h46);
    #2 rstN = 1'b0;
    #1;
    checkOutput("rst2.gntA", {7'd0, gntA}, 8'h00);
    checkOutput("rst2.wren", {7'd0, ramWren}, 8'h00);
    checkOutput("rst2.rvalidA", {7'd0, rvalidA}, 8'h00);
    checkOutput("rst2.owner", {6'd0, owner}, 8'h00);
    nextCycle();
    rstN = 1'b1;
    applyStimulus(1, 1, 0, 8'h07, 8'h99, 0, 0, 0, 8'h00, 8'h00);
    checkCycle("s30", 1, 0, 1, 0, 0, 2'b00, 8'h00);
    nextCycle();
    applyStimulus(1, 0, 0, 8'h07, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    checkCycle("s31", 1, 0, 0, 0, 0, 2'b00, 8'h00);
    nextCycle();
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    checkCycle("s32", 0, 0, 0, 1, 0, 2'b00, 8'h99);
    nextCycle();

    // B write and A read of the same address, B favoured by round-robin
    applyStimulus(1, 0, 0, 8'h80, 8'h00, 1, 1, 0, 8'h80, 8'hFF);
    checkCycle("s33", 0, 1, 1, 0, 0, 2'b00, 8'h00);
    checkOutput("s33.ramAddr", ramAddr, 8'h80);
    checkOutput("s33.ramData", ramData, 8'hFF);
    nextCycle();
    applyStimulus(1, 0, 0, 8'h80, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    checkCycle("s34", 1, 0, 0, 0, 0, 2'b00, 8'h00);
    nextCycle();
    applyStimulus(0, 0, 0, 8'h55, 8'h00, 0, 0, 0, 8'hAA, 8'h00);
    checkCycle("s35", 0, 0, 0, 1, 0, 2'b00, 8'hFF);
    checkOutput("s35.ramAddr", ramAddr, 8'h55);
    nextCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
